// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: accepts pt/key, runs rounds 1..NR on the engine, returns ct; per round ARM + engine latency.
// in_ready only in IDLE; ct/out_valid held until out_ready; a per-round watchdog aborts a hung engine.
module aes_round_ctrl #(
  parameter int NR        = 10,
  parameter int TO_CYCLES = 255,
  parameter int TW        = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic [3:0]   rnd_rc,
  output logic [127:0] rnd_data,
  output logic [127:0] rnd_key,
  output logic         rnd_rst_,
  input  logic         rnd_done,
  input  logic [127:0] rnd_out,
  input  logic [127:0] rnd_keyout,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] wdog;
  logic          accept;
  logic          last_rnd;
  logic          wd_exp;

  assign in_ready = (state == IDLE) & ~rst_;
  assign accept   = in_valid & in_ready;
  assign rnd_rst_ = (state == RUN);
  assign last_rnd = (rnd_rc == 4'(NR));
  // Expiry fires in the cycle the count would reach TO_CYCLES; a done in that cycle wins.
  assign wd_exp   = (wdog == TW'(TO_CYCLES - 1)) & ~rnd_done;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ARM;
      ARM:  state_nxt = RUN;
      RUN: begin
        if (rnd_done)    state_nxt = last_rnd ? DONE : ARM;
        else if (wd_exp) state_nxt = IDLE;
      end
      DONE: if (out_valid & out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      rnd_rc      <= '0;
      rnd_data    <= '0;
      rnd_key     <= '0;
      ct          <= '0;
      wdog        <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rnd_data    <= pt ^ key;
            rnd_key     <= key;
            rnd_rc      <= 4'd1;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ARM: wdog <= '0;
        RUN: begin
          wdog <= wdog + 1'b1;
          if (rnd_done) begin
            rnd_data <= rnd_out;
            rnd_key  <= rnd_keyout;
            if (last_rnd) begin
              ct        <= rnd_out;
              out_valid <= 1'b1;
            end else begin
              rnd_rc <= rnd_rc + 4'd1;
            end
          end else if (wd_exp) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rnd_rc      <= '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rnd_rc    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round engine attached.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int TO_CYCLES = 255;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_ = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] pt, key, ct;
  logic [3:0]   rnd_rc;
  logic [127:0] rnd_data, rnd_key, rnd_out, rnd_keyout;
  logic         rnd_rst_, rnd_done, busy, timeout_err;

  logic         eng_done = 1'b0, spur_done = 1'b0;
  logic [127:0] eng_out = '0, eng_key = '0, spur_out = '0, spur_key = '0;

  assign rnd_done   = eng_done | spur_done;
  assign rnd_out    = spur_done ? spur_out : eng_out;
  assign rnd_keyout = spur_done ? spur_key : eng_key;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR), .TO_CYCLES(TO_CYCLES), .TW(8)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
    .pt(pt), .key(key), .out_valid(out_valid), .out_ready(out_ready), .ct(ct),
    .rnd_rc(rnd_rc), .rnd_data(rnd_data), .rnd_key(rnd_key), .rnd_rst_(rnd_rst_),
    .rnd_done(rnd_done), .rnd_out(rnd_out), .rnd_keyout(rnd_keyout),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  end

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    case (r)
      4'd1: rc = 8'h01;  4'd2: rc = 8'h02;  4'd3: rc = 8'h04;  4'd4: rc = 8'h08;
      4'd5: rc = 8'h10;  4'd6: rc = 8'h20;  4'd7: rc = 8'h40;  4'd8: rc = 8'h80;
      4'd9: rc = 8'h1b;  4'd10: rc = 8'h36; default: rc = 8'h00;
    endcase
    {w0, w1, w2, w3} = k;
    t = {w3[23:0], w3[31:24]};
    t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ rk;
  endfunction

  // ---------------- behavioural round engine ----------------
  int lat  = 3;
  bit mute = 1'b0;
  int ecnt = 0;

  initial forever begin
    @(negedge clk);
    eng_done = 1'b0;
    if (!rnd_rst_) ecnt = 0;
    else begin
      ecnt++;
      if (!mute && ecnt == lat) begin
        eng_key  = key_next(rnd_key, rnd_rc);
        eng_out  = aes_round(rnd_data, eng_key, rnd_rc == 4'(NR));
        eng_done = 1'b1;
      end
    end
  end

  // ---------------- monitor: RUN entries, rc log, stability ----------------
  logic [3:0]   rc_hist [$];
  int           run_cnt = 0, ov_cnt = 0, stab_err = 0;
  logic         prev_run = 1'b0;
  logic [3:0]   prc = '0;
  logic [127:0] pdata = '0, pkey = '0;

  initial forever begin
    @(negedge clk);
    if (out_valid) ov_cnt++;
    if (rnd_rst_ && !prev_run) begin
      run_cnt++;
      rc_hist.push_back(rnd_rc);
    end else if (rnd_rst_ && (rnd_rc !== prc || rnd_data !== pdata || rnd_key !== pkey)) begin
      stab_err++;
    end
    prev_run = rnd_rst_;
    prc = rnd_rc; pdata = rnd_data; pkey = rnd_key;
  end

  // ---------------- handshake helpers ----------------
  task automatic send(input logic [127:0] p, input logic [127:0] k);
    int t;
    @(negedge clk);
    pt = p; key = k; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 10000) begin @(negedge clk); t++; end
    check("accept_wait", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic [127:0] exp, input string tag);
    int t;
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 10000) begin @(negedge clk); t++; end
    check({tag, "_ov"}, 128'(out_valid), 128'(1));
    check(tag, ct, exp);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int r0, h0, k, t, ov0, bp_err;
    logic ok;
    logic [127:0] s_data, s_key, s_ct;
    logic [5:0]   s_ctl;

    in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", 128'({in_ready, out_valid, busy, timeout_err, rnd_rst_, rnd_rc}), 128'(0));
    check("rst_data", rnd_data | rnd_key | ct, 128'(0));
    rst_ = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 128'(in_ready), 128'(1));

    // FIPS-197 vector, 10 rounds, rc 1..10
    r0 = run_cnt; h0 = rc_hist.size();
    send(P1, K1);
    recv(C1, "fips_ct");
    #1;
    check("arm_entries", 128'(run_cnt - r0), 128'(NR));
    ok = (rc_hist.size() >= h0 + NR);
    for (int i = 0; i < NR; i++)
      if (ok && rc_hist[h0+i] != 4'(i + 1)) ok = 1'b0;
    check("rc_seq", 128'(ok), 128'(1));

    // spurious done in IDLE
    @(negedge clk);
    s_data = rnd_data; s_key = rnd_key; s_ct = ct;
    s_ctl = {busy, out_valid, rnd_rc};
    spur_out = {4{32'hdeadbeef}}; spur_key = {4{32'h5a5a5a5a}}; spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_idle_data", rnd_data, s_data);
    check("spur_idle_key", rnd_key, s_key);
    check("spur_idle_ct", ct, s_ct);
    check("spur_idle_ctl", 128'({busy, out_valid, rnd_rc}), 128'(s_ctl));

    // spurious done in ARM
    pt = P2; key = K2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_arm_data", rnd_data, P2 ^ K2);
    check("spur_arm_key", rnd_key, K2);
    check("spur_arm_rc", 128'(rnd_rc), 128'(1));
    recv(C2, "spur_arm_ct");

    // watchdog: engine never completes
    mute = 1'b1;
    #1 ov0 = ov_cnt;
    send(P1, K1);
    t = 0;
    while (!rnd_rst_ && t < 10) begin @(negedge clk); t++; end
    k = 0;
    while (!timeout_err && k < 1000) begin @(negedge clk); k++; end
    check("wd_cycles", 128'(k), 128'(TO_CYCLES));
    check("wd_busy", 128'(busy), 128'(0));
    check("wd_in_ready", 128'(in_ready), 128'(1));
    check("wd_rc", 128'(rnd_rc), 128'(0));
    repeat (3) @(negedge clk);
    #1;
    check("wd_no_ov", 128'(ov_cnt - ov0), 128'(0));
    mute = 1'b0;

    // back-to-back with output backpressure; timeout_err clears on accept
    check("err_sticky", 128'(timeout_err), 128'(1));
    send(P1, K1);
    check("err_cleared", 128'(timeout_err), 128'(0));
    pt = P2; key = K2; in_valid = 1'b1;
    t = 0;
    while (!out_valid && t < 10000) begin @(negedge clk); t++; end
    check("bp_ov", 128'(out_valid), 128'(1));
    s_ct = ct; s_data = rnd_data; bp_err = 0;
    for (int i = 0; i < 20; i++) begin
      spur_done = (i == 10);
      @(negedge clk);
      spur_done = 1'b0;
      if (!out_valid || ct !== s_ct || rnd_data !== s_data || in_ready) bp_err++;
    end
    check("bp_hold", 128'(bp_err), 128'(0));
    check("b2b_ct1", ct, C1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_ov_drop", 128'(out_valid), 128'(0));
    check("b2b_rdy_next", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepted", 128'({busy, in_ready}), 128'(2'b10));
    recv(C2, "b2b_ct2");

    // done coincident with watchdog expiry
    lat = TO_CYCLES;
    send(P2, K2);
    recv(C2, "coinc_ct");
    check("coinc_err", 128'(timeout_err), 128'(0));
    lat = 3;

    // async reset during round 5
    lat = 20;
    send(P1, K1);
    t = 0;
    while (!(rnd_rst_ && rnd_rc == 4'd5) && t < 2000) begin @(negedge clk); t++; end
    check("rst_rnd5_reached", 128'(rnd_rc), 128'(5));
    #2 rst_ = 1'b1;
    #1;
    check("arst_ctl", 128'({in_ready, out_valid, busy, timeout_err, rnd_rst_, rnd_rc}), 128'(0));
    check("arst_data", rnd_data | rnd_key | ct, 128'(0));
    @(negedge clk);
    rst_ = 1'b0;
    #1 ov0 = ov_cnt;
    @(negedge clk);
    check("arst_rdy", 128'(in_ready), 128'(1));
    lat = 3;
    send(P2, K2);
    recv(C2, "post_rst_ct");
    #1;
    check("arst_one_ov", 128'(ov_cnt - ov0), 128'(1));
    check("run_stable", 128'(stab_err), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Top-level sequencer for the AES-128 round engine.
- Accepts plaintext and cipher key over a valid/ready handshake and performs the initial AddRoundKey.
- Drives the round engine through rc = 1..NR, capturing round state and round key on each engine completion pulse.
- Presents the final ciphertext over a valid/ready handshake and watchdogs each round for a missing completion pulse.

Parameters:
NR, 10, number of AES rounds; the engine's final-round path is selected when rc == NR
TO_CYCLES, 255, maximum cycles in RUN before a round is declared hung
TW, 8, width of the watchdog counter; must hold TO_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  reset, asynchronous, active-high
in_valid  in  1  pt/key offered
in_ready  out  1  controller can accept pt/key
pt  in  128  plaintext
key  in  128  cipher key (round 0 key)
out_valid  out  1  ct valid
out_ready  in  1  downstream accepts ct
ct  out  128  ciphertext
rnd_rc  out  4  round counter to engine
rnd_data  out  128  round input state to engine
rnd_key  out  128  previous round key to engine
rnd_rst_  out  1  engine hold, active-low; 0 forces engine to its idle state
rnd_done  in  1  engine single-cycle completion pulse
rnd_out  in  128  engine round output; valid in the rnd_done cycle
rnd_keyout  in  128  engine round key; valid in the rnd_done cycle
busy  out  1  operation in progress
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset values (async, while rst_ = 1):
  - State IDLE.
  - rnd_rc, rnd_data, rnd_key, ct, and the watchdog counter are 0.
  - rnd_rst_, out_valid, busy, and timeout_err are 0.
- in_ready = 1 only in IDLE and not in reset.
- States:
  - IDLE: rnd_rst_ = 0. When in_valid & in_ready:
    - rnd_data <= pt ^ key, rnd_key <= key, rnd_rc <= 1.
    - timeout_err <= 0, busy <= 1, go to ARM.
  - ARM: one cycle. rnd_rst_ = 0, watchdog <= 0. Go to RUN.
  - RUN: rnd_rst_ = 1; watchdog increments each cycle. On rnd_done:
    - rnd_data <= rnd_out, rnd_key <= rnd_keyout.
    - If rnd_rc == NR: ct <= rnd_out, out_valid <= 1, go to DONE.
    - Otherwise: rnd_rc <= rnd_rc + 1, go to ARM.
  - Watchdog expiry: if the watchdog reaches TO_CYCLES in RUN with no rnd_done, set timeout_err <= 1, busy <= 0, rnd_rc <= 0, and go to IDLE. out_valid is never asserted for that operation.
  - DONE: rnd_rst_ = 0. ct and out_valid are held stable until out_ready. On out_valid & out_ready: out_valid <= 0, busy <= 0, rnd_rc <= 0, go to IDLE.
- rnd_data, rnd_key, and rnd_rc are stable for the entire RUN interval. They change only on state transitions.
- rnd_done is ignored in every state except RUN.
- rnd_done in the same cycle the watchdog reaches TO_CYCLES: rnd_done wins and timeout_err stays 0.
- Latency:
  - 1 accept cycle.
  - Per round: 1 ARM cycle plus the engine latency to rnd_done.
  - out_valid rises the cycle after the final rnd_done.
  - The earliest new accept is the cycle after the output handshake.
- rnd_rc arithmetic is 4-bit with no wrap: the range 1..NR is guaranteed by the FSM.
- Reset mid-operation aborts immediately to reset values. The partial result is discarded and no out_valid is produced.
- timeout_err clears only on the next accepted input or on reset.

Test Plan:
1. FIPS-197 vector:
   - Stimulus: key = 000102030405060708090a0b0c0d0e0f, pt = 00112233445566778899aabbccddeeff, with the engine attached.
   - Required: ct = 69c4e0d86a7b0430d8cdb78070b4c55a; exactly 10 ARM entries; rnd_rc sequence 1..10.
2. Output backpressure:
   - Stimulus: hold out_ready = 0 for 20 cycles after out_valid.
   - Required: ct and out_valid are stable; in_ready = 0 throughout; first accept is one cycle after out_ready = 1.
3. Watchdog:
   - Stimulus: behavioural engine model never pulses rnd_done.
   - Required: timeout_err = 1 exactly TO_CYCLES cycles after RUN entry; busy = 0; in_ready = 1; out_valid never 1.
4. Spurious and boundary done:
   - Stimulus: pulse rnd_done in IDLE, in ARM, and in DONE.
   - Required: no register change.
   - Stimulus: rnd_done coincident with watchdog expiry.
   - Required: round completes and timeout_err = 0.
5. Async reset mid-round:
   - Stimulus: assert rst_ between clock edges during round 5.
   - Required: all outputs are 0 before the next edge; after release in_ready = 1; the next vector yields the correct ct.
6. Back-to-back operations:
   - Stimulus: two vectors with in_valid held high.
   - Required: second accepted only after the first output handshake; both ct correct; timeout_err from a prior failed run clears on accept.
